instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Packs RISC-V RV32I fields (format, opcode, regs, functs, immediate) into a 32-bit instruction
//  word; the inverse of the core's immediate decoding. Feeds the imem loader/boot path on the
//  Tang Nano 9k: accepted requests are range-checked, encoded and emitted through a one-entry
//  output register with a word address that auto-advances.
// PARAMETERS
//  ADDR_W  12  width of out_addr (byte address)
//  CNT_W   16  width of emit/error counters
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       request valid
//  in_ready   out  1       request accepted when in_valid & in_ready
//  in_fmt     in   3       0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
//  in_opcode  in   7       opcode field [6:0]
//  in_rd      in   5       rd [11:7] (R/I/U/J)
//  in_rs1     in   5       rs1 [19:15] (R/I/S/B)
//  in_rs2     in   5       rs2 [24:20] (R/S/B)
//  in_funct3  in   3       funct3 [14:12] (R/I/S/B)
//  in_funct7  in   7       funct7 [31:25] (R only)
//  in_imm     in   32      signed byte immediate (U: full 32-bit value, low 12 bits zero)
//  base_load  in   1       load address counter from base_addr
//  base_addr  in   ADDR_W  new start address (bits [1:0] forced to 0)
//  out_valid  out  1       encoded word valid
//  out_ready  in   1       consumer takes word when out_valid & out_ready
//  out_instr  out  32      encoded instruction
//  out_addr   out  ADDR_W  byte address of out_instr
//  out_err    out  1       word replaced by NOP due to encode error
//  emit_cnt   out  CNT_W   words emitted, saturating
//  err_cnt    out  CNT_W   errored words emitted, saturating
// BEHAVIOUR
//  Reset: out_valid=0, out_instr=0, out_err=0, addr counter=0, emit_cnt=0, err_cnt=0.
//  in_ready = ~out_valid | out_ready (combinational); latency 1 cycle accept->out_valid.
//  Output reg states EMPTY/FULL: EMPTY+accept->FULL; FULL+drain+accept->FULL (new word);
//  FULL+drain, no accept->EMPTY; FULL & ~out_ready -> hold all out_* stable.
//  Encoding: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op};
//  S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op};
//  U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//  Errors: I/S imm[31:11] not all equal; B imm[31:12] not all equal or imm[0]=1;
//  J imm[31:20] not all equal or imm[0]=1; U imm[11:0]!=0; fmt 6/7. R ignores in_imm.
//  On error: out_instr=32'h00000013 (NOP), out_err=1; word still emitted and addr still advances.
//  out_addr = counter value captured at accept; counter += 4 per accept, wraps mod 2^ADDR_W.
//  base_load: counter <= {base_addr[ADDR_W-1:2],2'b00}; wins over simultaneous accept increment
//  (the accepted word uses the old counter value). Does not alter a word already in out reg.
//  emit_cnt/err_cnt increment on accept, saturate at all-ones.
//  rst mid-operation: pending word discarded, no handshake completes that cycle.
// TESTING
//  fmt=I op=13 rd=1 rs1=0 f3=0 imm=5 -> next cycle out_instr=0x00500093, out_err=0, out_addr=0.
//  fmt=S op=23 rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423; B op=63 rs1=rs2=0 f3=0 imm=-4 -> 0xFE000EE3.
//  J op=6F rd=1 imm=8 -> 0x008000EF; U op=37 rd=5 imm=0x12345000 -> 0x123452B7; addrs 0,4,8...
//  I imm=2048, B imm=3, U imm=0x1001 -> each 0x00000013 with out_err=1, err_cnt=3, addr advances.
//  out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, out_* stable; release -> one drain.
//  base_load=1 base_addr=0x103 with accept same cycle -> word at old addr, next word at 0x100.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field packer with one-entry output register and auto-advancing word address
module instr_encoder #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [CNT_W-1:0]  emit_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;

  logic              accept, drain;
  logic [31:0]       enc;
  logic              enc_err;
  logic [ADDR_W-1:0] addr_cnt;
  logic              unused_bits;

  assign unused_bits = ^base_addr[1:0];

  // Reset blocks the input handshake so nothing is accepted in a reset cycle.
  assign in_ready  = ~rst & ((state == EMPTY) | out_ready);
  assign accept    = in_valid & in_ready;
  assign drain     = (state == FULL) & out_ready;
  assign out_valid = (state == FULL);

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (accept) state_nx = FULL;
      FULL:    if (drain && !accept) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  // Immediate must be representable in the format's sign-extended field.
  always_comb begin
    enc     = NOP;
    enc_err = 1'b0;
    case (in_fmt)
      3'd0: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: begin
        enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err = ~(&in_imm[31:11] | ~|in_imm[31:11]);
      end
      3'd2: begin
        enc     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err = ~(&in_imm[31:11] | ~|in_imm[31:11]);
      end
      3'd3: begin
        enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
        enc_err = ~(&in_imm[31:12] | ~|in_imm[31:12]) | in_imm[0];
      end
      3'd4: begin
        enc     = {in_imm[31:12], in_rd, in_opcode};
        enc_err = |in_imm[11:0];
      end
      3'd5: begin
        enc     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err = ~(&in_imm[31:20] | ~|in_imm[31:20]) | in_imm[0];
      end
      default: enc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
      emit_cnt  <= '0;
      err_cnt   <= '0;
      addr_cnt  <= '0;
    end else begin
      if (accept) begin
        out_instr <= enc_err ? NOP : enc;
        out_err   <= enc_err;
        out_addr  <= addr_cnt;
        if (emit_cnt != {CNT_W{1'b1}}) emit_cnt <= emit_cnt + 1'b1;
        if (enc_err && err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
      end
      // A base load overrides the post-accept increment; the accepted word keeps the old address.
      if (base_load)   addr_cnt <= {base_addr[ADDR_W-1:2], 2'b00};
      else if (accept) addr_cnt <= addr_cnt + ADDR_W'(4);
    end
  end

endmodule
